// File: rtl/escalator_scheduler.sv
// escalator_scheduler: direction scheduler for a single reversible escalator.
// Latches up/down calls, tracks belt occupancy from entry/exit pulses, grants
// one direction at a time, drains the belt before any reversal and holds a
// brake dwell after every run. Motor code: 00 stop, 01 up, 10 down.
// Optional build macro ESC_EMERGENCY_STOP_EN adds an estop input and a HALT
// state that overrides every other transition.
module escalator_scheduler #(
   parameter int IDLE_TIMEOUT = 200,
   parameter int BRAKE_TIME   = 50,
   parameter int MAX_RUN      = 1000,
   parameter int OCC_W        = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_up,
   input  logic             req_down,
   input  logic             entry_bot,
   input  logic             entry_top,
   input  logic             exit_bot,
   input  logic             exit_top,
`ifdef ESC_EMERGENCY_STOP_EN
   input  logic             estop,
`endif
   output logic [1:0]       direction,
   output logic             gate_open,
   output logic [OCC_W-1:0] occupancy,
   output logic             err_underflow
);

   localparam int RUN_W = $clog2(MAX_RUN + 1);
   localparam int IDL_W = $clog2(IDLE_TIMEOUT + 1);
   localparam int BRK_W = $clog2(BRAKE_TIME + 1);

   localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(MAX_RUN - 1);
   localparam logic [IDL_W-1:0] IDL_LIM = IDL_W'(IDLE_TIMEOUT - 1);
   localparam logic [BRK_W-1:0] BRK_LIM = BRK_W'(BRAKE_TIME - 1);

   localparam logic signed [OCC_W+1:0] OCC_MAX = {2'b00, {OCC_W{1'b1}}};

   localparam logic [1:0] DIR_STOP = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN_UP,
      S_RUN_DOWN,
      S_DRAIN_UP,
      S_DRAIN_DOWN,
      S_BRAKE
`ifdef ESC_EMERGENCY_STOP_EN
      , S_HALT
`endif
   } state_t;

   state_t           state_q, state_d;
   logic             pend_up_q, pend_up_d;
   logic             pend_down_q, pend_down_d;
   logic             last_up_q, last_up_d;
   logic [RUN_W-1:0] run_timer_q, run_timer_d;
   logic [IDL_W-1:0] idle_timer_q, idle_timer_d;
   logic [BRK_W-1:0] brake_timer_q, brake_timer_d;
   logic [OCC_W-1:0] occupancy_q, occupancy_d;
   logic             err_underflow_q, err_underflow_d;
   logic [1:0]       direction_q, direction_d;
   logic             gate_open_q, gate_open_d;

   logic [1:0]        n_in, n_out;
   logic signed [2:0] occ_delta;
   logic              under_step;
   logic              any_entry;
   logic              grant_up, grant_down, opp_pending;

   // Apply a signed delta to the count, saturating high and clamping at zero.
   // Returns {underflow_flag, new_count}.
   function automatic logic [OCC_W:0] occ_step(input logic [OCC_W-1:0] occ,
                                               input logic signed [2:0] delta);
      logic signed [OCC_W+1:0] sum;
      sum = $signed({2'b00, occ}) + (OCC_W+2)'(delta);
      if (sum[OCC_W+1]) begin
         occ_step = {1'b1, {OCC_W{1'b0}}};
      end else if (sum > OCC_MAX) begin
         occ_step = {1'b0, {OCC_W{1'b1}}};
      end else begin
         occ_step = {1'b0, sum[OCC_W-1:0]};
      end
   endfunction

   // Net passenger movement this cycle and the resulting occupancy.
   always_comb begin
      n_in      = {1'b0, entry_bot} + {1'b0, entry_top};
      n_out     = {1'b0, exit_bot} + {1'b0, exit_top};
      occ_delta = $signed({1'b0, n_in}) - $signed({1'b0, n_out});
      {under_step, occupancy_d} = occ_step(occupancy_q, occ_delta);
      err_underflow_d = err_underflow_q | under_step;
   end

   // Next-state logic: grants, run/idle timers, drain and brake sequencing.
   always_comb begin
      state_d       = state_q;
      pend_up_d     = pend_up_q | req_up;
      pend_down_d   = pend_down_q | req_down;
      last_up_d     = last_up_q;
      run_timer_d   = run_timer_q;
      idle_timer_d  = idle_timer_q;
      brake_timer_d = brake_timer_q;
      any_entry     = entry_bot | entry_top;
      // On a tie the grant goes opposite to the last direction served.
      grant_up      = pend_up_q & (~pend_down_q | ~last_up_q);
      grant_down    = pend_down_q & (~pend_up_q | last_up_q);
      opp_pending   = (state_q == S_RUN_UP) ? pend_down_q : pend_up_q;

      case (state_q)
         S_IDLE: begin
            if (grant_up) begin
               state_d      = S_RUN_UP;
               pend_up_d    = req_up;
               last_up_d    = 1'b1;
               run_timer_d  = '0;
               idle_timer_d = '0;
            end else if (grant_down) begin
               state_d      = S_RUN_DOWN;
               pend_down_d  = req_down;
               last_up_d    = 1'b0;
               run_timer_d  = '0;
               idle_timer_d = '0;
            end
         end
         S_RUN_UP, S_RUN_DOWN: begin
            run_timer_d = (run_timer_q == '1) ? run_timer_q : run_timer_q + 1'b1;
            if (any_entry) begin
               idle_timer_d = '0;
            end else begin
               idle_timer_d = (idle_timer_q == '1) ? idle_timer_q : idle_timer_q + 1'b1;
            end
            if (opp_pending && (run_timer_q >= RUN_LIM)) begin
               state_d = (state_q == S_RUN_UP) ? S_DRAIN_UP : S_DRAIN_DOWN;
            end else if ((idle_timer_q >= IDL_LIM) && (occupancy_q == '0)) begin
               state_d       = S_BRAKE;
               brake_timer_d = '0;
            end
         end
         S_DRAIN_UP, S_DRAIN_DOWN: begin
            if (occupancy_q == '0) begin
               state_d       = S_BRAKE;
               brake_timer_d = '0;
            end
         end
         S_BRAKE: begin
            if (brake_timer_q == BRK_LIM) begin
               state_d = S_IDLE;
            end else begin
               brake_timer_d = brake_timer_q + 1'b1;
            end
         end
`ifdef ESC_EMERGENCY_STOP_EN
         S_HALT: begin
            if (!estop) begin
               state_d       = S_BRAKE;
               brake_timer_d = '0;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase

`ifdef ESC_EMERGENCY_STOP_EN
      // Emergency stop overrides everything; no run is granted while held.
      if (estop) begin
         state_d     = S_HALT;
         pend_up_d   = pend_up_q | req_up;
         pend_down_d = pend_down_q | req_down;
         last_up_d   = last_up_q;
      end
`endif
   end

   // Outputs decoded from the next state so they are registered with it.
   always_comb begin
      direction_d = DIR_STOP;
      gate_open_d = 1'b0;
      case (state_d)
         S_RUN_UP: begin
            direction_d = DIR_UP;
            gate_open_d = 1'b1;
         end
         S_RUN_DOWN: begin
            direction_d = DIR_DOWN;
            gate_open_d = 1'b1;
         end
         S_DRAIN_UP:   direction_d = DIR_UP;
         S_DRAIN_DOWN: direction_d = DIR_DOWN;
         default: begin
            direction_d = DIR_STOP;
            gate_open_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset stops the belt and discards the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_IDLE;
         pend_up_q       <= 1'b0;
         pend_down_q     <= 1'b0;
         last_up_q       <= 1'b0;
         run_timer_q     <= '0;
         idle_timer_q    <= '0;
         brake_timer_q   <= '0;
         occupancy_q     <= '0;
         err_underflow_q <= 1'b0;
         direction_q     <= DIR_STOP;
         gate_open_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         pend_up_q       <= pend_up_d;
         pend_down_q     <= pend_down_d;
         last_up_q       <= last_up_d;
         run_timer_q     <= run_timer_d;
         idle_timer_q    <= idle_timer_d;
         brake_timer_q   <= brake_timer_d;
         occupancy_q     <= occupancy_d;
         err_underflow_q <= err_underflow_d;
         direction_q     <= direction_d;
         gate_open_q     <= gate_open_d;
      end
   end

   assign direction     = direction_q;
   assign gate_open     = gate_open_q;
   assign occupancy     = occupancy_q;
   assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_escalator_scheduler.sv
// Testbench for escalator_scheduler: directed scenarios plus random traffic,
// checked by a scoreboard fed from a behavioural model of the scheduler.
module tb_escalator_scheduler;

   localparam int IT   = 10;
   localparam int BT   = 4;
   localparam int MR   = 20;
   localparam int OW   = 4;
   localparam int OMAX = (1 << OW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_up = 1'b0, req_down = 1'b0;
   logic          entry_bot = 1'b0, entry_top = 1'b0;
   logic          exit_bot = 1'b0, exit_top = 1'b0;
`ifdef ESC_EMERGENCY_STOP_EN
   logic          estop = 1'b0;
`endif
   logic [1:0]    direction;
   logic          gate_open;
   logic [OW-1:0] occupancy;
   logic          err_underflow;

   always #5 clk = ~clk;

   escalator_scheduler #(
      .IDLE_TIMEOUT(IT),
      .BRAKE_TIME(BT),
      .MAX_RUN(MR),
      .OCC_W(OW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req_up(req_up),
      .req_down(req_down),
      .entry_bot(entry_bot),
      .entry_top(entry_top),
      .exit_bot(exit_bot),
      .exit_top(exit_top),
`ifdef ESC_EMERGENCY_STOP_EN
      .estop(estop),
`endif
      .direction(direction),
      .gate_open(gate_open),
      .occupancy(occupancy),
      .err_underflow(err_underflow)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", nm, got, want);
      end
   endtask

   // ---------------- behavioural model + scoreboard ----------------
   typedef struct {
      int dir;
      int gate;
      int occ;
      int err;
   } exp_t;

   exp_t sb[$];

   localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_BRAKE = 3, M_HALT = 4;
   int mode = M_IDLE;
   int mdir = 0;        // 1 up, 2 down while running/draining
   int pu = 0, pd = 0;
   int last_up = 0;
   int rc = 0, ic = 0, bc = 0;
   int occ = 0, err = 0;

   task automatic model_step();
      exp_t e;
      int ent, ext, nocc, gu, gd, opp, es;
      if (reset) begin
         mode = M_IDLE; mdir = 0; pu = 0; pd = 0; last_up = 0;
         rc = 0; ic = 0; bc = 0; occ = 0; err = 0;
      end else begin
         ent = int'(entry_bot) + int'(entry_top);
         ext = int'(exit_bot) + int'(exit_top);
         nocc = occ + ent - ext;
         if (nocc < 0) begin nocc = 0; err = 1; end
         if (nocc > OMAX) nocc = OMAX;
         gu = 0; gd = 0; es = 0;
`ifdef ESC_EMERGENCY_STOP_EN
         es = int'(estop);
`endif
         if (es != 0) begin
            mode = M_HALT;
         end else begin
            case (mode)
               M_IDLE: begin
                  if (pu != 0 && pd != 0) begin
                     if (last_up != 0) gd = 1; else gu = 1;
                  end else if (pu != 0) gu = 1;
                  else if (pd != 0) gd = 1;
                  if (gu != 0 || gd != 0) begin
                     mode = M_RUN; mdir = (gu != 0) ? 1 : 2;
                     last_up = gu; rc = 0; ic = 0;
                  end
               end
               M_RUN: begin
                  opp = (mdir == 1) ? pd : pu;
                  if (opp != 0 && rc >= MR - 1) mode = M_DRAIN;
                  else if (ic >= IT - 1 && occ == 0) begin mode = M_BRAKE; bc = 0; end
                  else begin
                     rc++;
                     ic = (ent > 0) ? 0 : ic + 1;
                  end
               end
               M_DRAIN: if (occ == 0) begin mode = M_BRAKE; bc = 0; end
               M_BRAKE: if (bc == BT - 1) mode = M_IDLE; else bc++;
               M_HALT:  begin mode = M_BRAKE; bc = 0; end
               default: mode = M_IDLE;
            endcase
         end
         pu = ((gu != 0) ? 0 : pu) | int'(req_up);
         pd = ((gd != 0) ? 0 : pd) | int'(req_down);
         occ = nocc;
      end
      e.dir  = (mode == M_RUN || mode == M_DRAIN) ? mdir : 0;
      e.gate = (mode == M_RUN) ? 1 : 0;
      e.occ  = occ;
      e.err  = err;
      sb.push_back(e);
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Monitor: one expected record per clock, compared on the falling edge.
   int prev_dir = 0;
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("sb_direction", int'(direction), e.dir);
         check("sb_gate_open", int'(gate_open), e.gate);
         check("sb_occupancy", int'(occupancy), e.occ);
         check("sb_err_underflow", int'(err_underflow), e.err);
         check("no_direct_reversal",
               ((prev_dir == 1 && direction == 2'b10) ||
                (prev_dir == 2 && direction == 2'b01)) ? 1 : 0, 0);
         prev_dir = int'(direction);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
      req_up = 1'b0; req_down = 1'b0;
      entry_bot = 1'b0; entry_top = 1'b0;
      exit_bot = 1'b0; exit_top = 1'b0;
   endtask

   task automatic idle_n(input int n);
      repeat (n) cyc();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   task automatic wait_dir(input logic [1:0] v, input int maxc, input string nm);
      int k = 0;
      while (direction !== v && k < maxc) begin
         cyc();
         k++;
      end
      check(nm, int'(direction), int'(v));
   endtask

   // Cycles until direction equals v (bounded); returns maxc+1 on timeout.
   task automatic count_to_dir(input logic [1:0] v, input int maxc, output int k);
      k = 0;
      while (direction !== v && k <= maxc) begin
         cyc();
         k++;
      end
   endtask

   initial begin
      int k;
      do_reset();
      check("reset_direction", int'(direction), 0);
      check("reset_gate", int'(gate_open), 0);
      check("reset_occupancy", int'(occupancy), 0);
      check("reset_err", int'(err_underflow), 0);

      // Grant latency, occupancy tracking, idle stop, brake dwell.
      req_up = 1'b1;
      cyc();
      check("pre_grant_stop", int'(direction), 0);
      cyc();
      check("grant_up_dir", int'(direction), 1);
      check("grant_up_gate", int'(gate_open), 1);
      repeat (3) begin entry_bot = 1'b1; cyc(); end
      check("occ_after_entries", int'(occupancy), 3);
      repeat (3) begin exit_top = 1'b1; cyc(); end
      check("occ_after_exits", int'(occupancy), 0);
      count_to_dir(2'b00, 40, k);
      check("idle_stop_delay", k, IT - 3);
      req_up = 1'b1;
      count_to_dir(2'b01, 40, k);
      check("brake_then_regrant", k, BT + 1);
      wait_dir(2'b00, 40, "second_run_idles");
      idle_n(BT + 2);

      // Forced drain with passengers aboard, then reversal via brake.
      do_reset();
      req_up = 1'b1;
      cyc();
      wait_dir(2'b01, 5, "drain_grant_up");
      repeat (2) begin entry_bot = 1'b1; cyc(); end
      req_down = 1'b1;
      cyc();
      k = 0;
      while (gate_open === 1'b1 && k <= 40) begin cyc(); k++; end
      check("drain_after_max_run", k, MR - 3);
      check("drain_keeps_dir", int'(direction), 1);
      idle_n(3);
      check("drain_holds_occupied", int'(direction), 1);
      repeat (2) begin exit_top = 1'b1; cyc(); end
      count_to_dir(2'b10, 40, k);
      check("reverse_after_brake", k, BT + 2);
      wait_dir(2'b00, 40, "down_run_ends");
      idle_n(BT + 2);

      // Tie-breaking alternates by last served direction.
      do_reset();
      req_up = 1'b1; req_down = 1'b1;
      cyc();
      cyc();
      check("tie_after_reset_up", int'(direction), 1);
      wait_dir(2'b10, 60, "leftover_down_granted");
      wait_dir(2'b00, 60, "down_run_stops");
      idle_n(BT + 2);
      req_up = 1'b1;
      cyc();
      wait_dir(2'b01, 5, "plain_up");
      wait_dir(2'b00, 60, "plain_up_stops");
      idle_n(BT + 2);
      req_up = 1'b1; req_down = 1'b1;
      cyc();
      cyc();
      check("tie_after_up_down", int'(direction), 2);
      wait_dir(2'b00, 60, "tie2_stops");
      idle_n(BT + 2);

      // Underflow flag, simultaneous entry/exit, saturation.
      do_reset();
      exit_bot = 1'b1;
      cyc();
      check("underflow_occ", int'(occupancy), 0);
      check("underflow_flag", int'(err_underflow), 1);
      idle_n(3);
      check("underflow_sticky", int'(err_underflow), 1);
      repeat (5) begin entry_bot = 1'b1; cyc(); end
      check("occ_five", int'(occupancy), 5);
      entry_bot = 1'b1; exit_top = 1'b1;
      cyc();
      check("occ_net_zero", int'(occupancy), 5);
      repeat (10) begin entry_bot = 1'b1; entry_top = 1'b1; cyc(); end
      check("occ_saturate", int'(occupancy), OMAX);
      exit_bot = 1'b1; exit_top = 1'b1;
      cyc();
      check("occ_double_exit", int'(occupancy), OMAX - 2);
      do_reset();
      check("err_cleared_by_reset", int'(err_underflow), 0);

`ifdef ESC_EMERGENCY_STOP_EN
      // Emergency stop mid down-run, up call latched while halted.
      req_down = 1'b1;
      cyc();
      wait_dir(2'b10, 5, "estop_pre_down");
      idle_n(2);
      estop = 1'b1;
      req_up = 1'b1;
      cyc();
      check("estop_halt_dir", int'(direction), 0);
      check("estop_halt_gate", int'(gate_open), 0);
      idle_n(2);
      estop = 1'b0;
      cyc();
      count_to_dir(2'b01, 40, k);
      check("estop_brake_then_up", k, BT + 1);
      wait_dir(2'b00, 60, "estop_up_stops");
      idle_n(BT + 2);
`endif

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         req_up    = ($urandom_range(0, 15) == 0);
         req_down  = ($urandom_range(0, 15) == 0);
         entry_bot = ($urandom_range(0, 3) == 0);
         entry_top = ($urandom_range(0, 5) == 0);
         exit_bot  = ($urandom_range(0, 4) == 0);
         exit_top  = ($urandom_range(0, 3) == 0);
`ifdef ESC_EMERGENCY_STOP_EN
         if ($urandom_range(0, 149) == 0) estop = ~estop;
`endif
         if ($urandom_range(0, 999) == 0) reset = 1'b1;
         cyc();
         reset = 1'b0;
      end
`ifdef ESC_EMERGENCY_STOP_EN
      estop = 1'b0;
`endif
      idle_n(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/escalator_scheduler.md
Name: escalator_scheduler

Overview:
Direction scheduler for a single reversible escalator shared by passengers queuing at the bottom (want up) and at the top (want down). Tracks on-belt occupancy from entry/exit sensors and grants the belt to one direction at a time. Enforces drain-before-reverse and a fixed brake dwell on every stop. Fairness is run-time bounded. Drives the motor direction code 00 stop / 01 up / 10 down.

Parameters:
IDLE_TIMEOUT, 200, cycles with no entry (and occupancy 0) before a running belt stops
BRAKE_TIME, 50, cycles the belt is held at stop after any run ends
MAX_RUN, 1000, run cycles after which a pending opposite request forces a drain
OCC_W, 8, occupancy counter width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
req_up  in  1  bottom call button, level or pulse; latched
req_down  in  1  top call button, level or pulse; latched
entry_bot  in  1  one-cycle pulse, passenger stepped on at bottom
entry_top  in  1  one-cycle pulse, passenger stepped on at top
exit_bot  in  1  one-cycle pulse, passenger stepped off at bottom
exit_top  in  1  one-cycle pulse, passenger stepped off at top
direction  out  2  00 stop, 01 up, 10 down; registered
gate_open  out  1  1 = entry gate at the active boarding end may admit passengers
occupancy  out  OCC_W  passengers currently on belt
err_underflow  out  1  sticky; exit seen with occupancy 0

Behaviour:
- Reset (synchronous, active-high): state IDLE, direction 00, gate_open 0, occupancy 0, pend_up/pend_down 0, timers 0, err_underflow 0, last_dir = down, so the first tie grants up.
- Pending latches: pend_up set by req_up, pend_down set by req_down, in any state. Each latch clears on the cycle its direction's run is entered. A request asserted on that same cycle is re-latched.
- Occupancy: net delta = (entry_bot + entry_top) - (exit_bot + exit_top), applied each cycle.
  - Saturates at 2^OCC_W-1.
  - A decrement that would go below 0 clamps to 0 and sets err_underflow. err_underflow clears only on reset.
- All outputs are registered. A state change decided on edge N is visible after edge N.
- FSM:
  - IDLE: direction 00, gate_open 0.
    - Only pend_up: go to RUN_UP.
    - Only pend_down: go to RUN_DOWN.
    - Both: grant the direction opposite last_dir.
    - Neither: stay.
  - RUN_UP / RUN_DOWN: direction 01 / 10, gate_open 1. On entry, clear the pending latch, set last_dir, and zero run_timer and idle_timer.
    - run_timer increments every cycle, saturating.
    - idle_timer increments every cycle and zeroes on any entry pulse.
    - If the opposite request is pending and run_timer >= MAX_RUN-1: go to DRAIN.
    - Else if idle_timer >= IDLE_TIMEOUT-1 and occupancy == 0: go to BRAKE.
    - If both conditions are true, DRAIN takes priority.
  - DRAIN_UP / DRAIN_DOWN: direction unchanged, gate_open 0.
    - Entries still count toward occupancy and are not blocked by the FSM.
    - When occupancy == 0 (registered value): go to BRAKE.
  - BRAKE: direction 00, gate_open 0; brake_timer counts from 0. At brake_timer == BRAKE_TIME-1, go to IDLE. Requests arriving during BRAKE are latched.
- Reversal always passes through DRAIN or idle-stop, then BRAKE, then IDLE. A direct 01<->10 change is illegal and must never appear on direction.
- Reset mid-run: direction is 00 on the next cycle and the occupancy count is discarded.

Optional Feature:
ESC_EMERGENCY_STOP_EN
- Defined:
  - Adds input estop (1 bit, active-high, level).
  - While estop == 1: the FSM enters HALT from any state on the next edge. HALT drives direction 00 and gate_open 0. Occupancy and pending latches keep updating.
  - When estop falls: HALT goes to BRAKE for the full BRAKE_TIME, then IDLE.
  - estop has priority over every other transition.
- Undefined: no estop port and no HALT state.

Test Plan:
- Run with IDLE_TIMEOUT=10, BRAKE_TIME=4, MAX_RUN=20.
- Reset, then pulse req_up: direction 01 one cycle after req_up is latched. gate_open=1. pend_up clears.
- In RUN_UP: 3 entry_bot pulses, then 3 exit_top pulses, then quiet. occupancy 3->0. Direction 01 until idle_timer reaches 10 with occupancy 0. Then 00 for exactly 4 cycles (BRAKE), then IDLE.
- In RUN_UP with occupancy 2: assert req_down. Direction stays 01 until run_timer hits 20. Then DRAIN: gate_open=0, direction 01. After 2 exit_top pulses, BRAKE 4 cycles at 00, then 10. Direction never goes 01->10 in one step.
- req_up and req_down together from IDLE after reset: grant up. After that run completes, simultaneous requests again: grant down.
- exit_bot with occupancy 0: occupancy stays 0, err_underflow=1 and held. Simultaneous entry_bot+exit_top with occupancy 5: occupancy stays 5.
- With ESC_EMERGENCY_STOP_EN, estop for 3 cycles mid RUN_DOWN: direction 00 on the next edge. After estop falls, 4 BRAKE cycles, then IDLE. A pend_up latched during HALT is then granted.
